pdp8_ifd_core: RTL

Instruction fetch/decode unit for the PDP-8 core, and the issuing end of the IFD↔exec interface. It fetches the 12-bit word at PC from memory and resolves indirect/auto-index effective addresses. It then presents one-hot decoded opcodes plus base_addr to the execute unit and holds them until exec acknowledges with stall. It takes the next PC from exec when stall releases.

---
 rtl/pdp8_ifd_core.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pdp8_ifd_core.sv
// rtl/pdp8_ifd_core.sv - PDP-8 instruction fetch/decode unit issuing one-hot opcodes to exec
//
// Purpose: fetches the word at PC, resolves indirect and auto-index effective
// addresses, decodes memory-reference and operate (op7) instructions, and
// holds the decoded flags plus base_addr until exec acknowledges with stall.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   stall, PC_value     exec handshake: busy flag and next PC (taken on stall low)
//   base_addr           effective address for memory-reference ops
//   pdp_mem_opcode      one-hot AND/TAD/ISZ/DCA/JMS/JMP
//   pdp_op7_opcode      operate microcode flags
//   mem_rd_*            read request pulse/address, read data return strobe/data
//   mem_wr_*            write pulse/address/data (auto-index pointer update)
//   iot_skip            one-cycle pulse when an IOT is skipped

package pdp8_ifd_pkg;
  typedef struct packed {
    logic AND;
    logic TAD;
    logic ISZ;
    logic DCA;
    logic JMS;
    logic JMP;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP;
    logic IAC;
    logic RAL;
    logic RTL;
    logic RAR;
    logic RTR;
    logic CML;
    logic CMA;
    logic CIA;
    logic CLL;
    logic CLA1;
    logic CLA_CLL;
    logic CLA2;
    logic HLT;
    logic OSR;
    logic SKP;
    logic SNL;
    logic SZL;
    logic SZA;
    logic SNA;
    logic SMA;
    logic SPA;
  } pdp_op7_opcode_s;
endpackage

module pdp8_ifd_core
  import pdp8_ifd_pkg::*;
#(
  parameter logic [11:0] START_ADDR = 12'o0200,
  parameter int          ADDR_WIDTH = 12,
  parameter int          DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] PC_value,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output pdp_mem_opcode_s       pdp_mem_opcode,
  output pdp_op7_opcode_s       pdp_op7_opcode,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  iot_skip
);

  typedef enum logic [3:0] {
    S_FETCH, S_WAIT_IR, S_DECODE, S_IND_RD, S_WAIT_IND,
    S_AUTO_WR, S_ISSUE, S_WAIT_ACK, S_WAIT_EXEC
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] ea_q, ea_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  pdp_mem_opcode_s       pend_mem_q, pend_mem_d;
  pdp_op7_opcode_s       pend_op7_q, pend_op7_d;
  logic [ADDR_WIDTH-1:0] base_addr_q, base_addr_d;
  pdp_mem_opcode_s       mem_op_q, mem_op_d;
  pdp_op7_opcode_s       op7_q, op7_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_req_q, wr_req_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  iot_q, iot_d;

  // Decode of the latched IR; only consumed in DECODE.
  logic [2:0]            opc;
  logic [ADDR_WIDTH-8:0] page;
  logic [ADDR_WIDTH-1:0] ea_dec;
  pdp_mem_opcode_s       mem_dec;
  pdp_op7_opcode_s       op7_dec;
  logic                  auto_idx;

  assign opc      = ir_q[11:9];
  assign page     = ir_q[7] ? pc_q[ADDR_WIDTH-1:7] : '0;
  assign ea_dec   = {page, ir_q[6:0]};
  // Auto-index locations are 0o010..0o017.
  assign auto_idx = (ea_q[ADDR_WIDTH-1:3] == (ADDR_WIDTH-3)'(1));

  always_comb begin
    mem_dec = '0;
    op7_dec = '0;
    case (opc)
      3'd0:    mem_dec.AND = 1'b1;
      3'd1:    mem_dec.TAD = 1'b1;
      3'd2:    mem_dec.ISZ = 1'b1;
      3'd3:    mem_dec.DCA = 1'b1;
      3'd4:    mem_dec.JMS = 1'b1;
      3'd5:    mem_dec.JMP = 1'b1;
      default: mem_dec = '0;
    endcase
    if (opc == 3'd7) begin
      if (!ir_q[8]) begin
        // Group 1: combined micro-ops replace their component flags.
        op7_dec.CML = ir_q[4];
        op7_dec.RAR = ir_q[3] & ~ir_q[1];
        op7_dec.RTR = ir_q[3] &  ir_q[1];
        op7_dec.RAL = ir_q[2] & ~ir_q[1];
        op7_dec.RTL = ir_q[2] &  ir_q[1];
        if (ir_q[5] && ir_q[0]) begin
          op7_dec.CIA = 1'b1;
        end else begin
          op7_dec.CMA = ir_q[5];
          op7_dec.IAC = ir_q[0];
        end
        if (ir_q[7] && ir_q[6]) begin
          op7_dec.CLA_CLL = 1'b1;
        end else begin
          op7_dec.CLA1 = ir_q[7];
          op7_dec.CLL  = ir_q[6];
        end
      end else if (!ir_q[0]) begin
        // Group 2: b3 selects the inverted skip sense.
        op7_dec.CLA2 = ir_q[7];
        op7_dec.OSR  = ir_q[2];
        op7_dec.HLT  = ir_q[1];
        if (!ir_q[3]) begin
          op7_dec.SMA = ir_q[6];
          op7_dec.SZA = ir_q[5];
          op7_dec.SNL = ir_q[4];
        end else begin
          op7_dec.SPA = ir_q[6];
          op7_dec.SNA = ir_q[5];
          op7_dec.SZL = ir_q[4];
          op7_dec.SKP = (ir_q[6:4] == 3'b000);
        end
      end
      // Exec always gets at least one flag; group 3 lands here too.
      op7_dec.NOP = (op7_dec == '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ea_d        = ea_q;
    target_d    = target_q;
    pend_mem_d  = pend_mem_q;
    pend_op7_d  = pend_op7_q;
    base_addr_d = base_addr_q;
    mem_op_d    = mem_op_q;
    op7_d       = op7_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_req_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    iot_d       = 1'b0;
    case (state_q)
      S_FETCH: begin
        rd_req_d  = 1'b1;
        rd_addr_d = pc_q;
        state_d   = S_WAIT_IR;
      end
      S_WAIT_IR: begin
        if (mem_rd_valid) begin
          ir_d    = mem_rd_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ea_d       = ea_dec;
        target_d   = ea_dec;
        pend_mem_d = mem_dec;
        pend_op7_d = op7_dec;
        if (opc == 3'd6) begin
          iot_d   = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = S_FETCH;
        end else if (opc == 3'd7 || !ir_q[8]) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IND_RD;
        end
      end
      S_IND_RD: begin
        rd_req_d  = 1'b1;
        rd_addr_d = ea_q;
        state_d   = S_WAIT_IND;
      end
      S_WAIT_IND: begin
        if (mem_rd_valid) begin
          if (auto_idx) begin
            target_d = ADDR_WIDTH'(mem_rd_data) + ADDR_WIDTH'(1);
            state_d  = S_AUTO_WR;
          end else begin
            target_d = ADDR_WIDTH'(mem_rd_data);
            state_d  = S_ISSUE;
          end
        end
      end
      S_AUTO_WR: begin
        wr_req_d  = 1'b1;
        wr_addr_d = ea_q;
        wr_data_d = DATA_WIDTH'(target_q);
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        base_addr_d = target_q;
        mem_op_d    = pend_mem_q;
        op7_d       = pend_op7_q;
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Flags drop on acknowledge so exec sees exactly one issue.
        if (stall) begin
          mem_op_d = '0;
          op7_d    = '0;
          state_d  = S_WAIT_EXEC;
        end
      end
      S_WAIT_EXEC: begin
        if (!stall) begin
          pc_d    = PC_value;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pc_q        <= ADDR_WIDTH'(START_ADDR);
      ir_q        <= '0;
      ea_q        <= '0;
      target_q    <= '0;
      pend_mem_q  <= '0;
      pend_op7_q  <= '0;
      base_addr_q <= '0;
      mem_op_q    <= '0;
      op7_q       <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      iot_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ea_q        <= ea_d;
      target_q    <= target_d;
      pend_mem_q  <= pend_mem_d;
      pend_op7_q  <= pend_op7_d;
      base_addr_q <= base_addr_d;
      mem_op_q    <= mem_op_d;
      op7_q       <= op7_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      iot_q       <= iot_d;
    end
  end

  assign base_addr      = base_addr_q;
  assign pdp_mem_opcode = mem_op_q;
  assign pdp_op7_opcode = op7_q;
  assign mem_rd_req     = rd_req_q;
  assign mem_rd_addr    = rd_addr_q;
  assign mem_wr_req     = wr_req_q;
  assign mem_wr_addr    = wr_addr_q;
  assign mem_wr_data    = wr_data_q;
  assign iot_skip       = iot_q;

endmodule
